// File: rtl/mpf_vtp_xlate_error_sink.sv
// Drops requests that failed VTP translation and synthesizes in-order error completions for them.
// Optional error counters are built when MPF_VTP_XLATE_ERR_STATS_EN is defined.
module mpf_vtp_xlate_error_sink #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int USER_WIDTH      = 8,
    parameter int UFLAG_NO_REPLY  = 0,
    parameter int MAX_OUTSTANDING = 64,
    localparam int DATA_N_BYTES   = DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       s_rd_read,
    input  logic [ADDR_WIDTH-1:0]      s_rd_address,
    input  logic [BURST_CNT_WIDTH-1:0] s_rd_burstcount,
    input  logic [DATA_N_BYTES-1:0]    s_rd_byteenable,
    input  logic [USER_WIDTH-1:0]      s_rd_user,
    input  logic                       s_rd_error,
    output logic                       s_rd_waitrequest,
    output logic                       s_rd_readdatavalid,
    output logic [DATA_WIDTH-1:0]      s_rd_readdata,
    output logic                       s_rd_resp_error,

    input  logic                       s_wr_write,
    input  logic [ADDR_WIDTH-1:0]      s_wr_address,
    input  logic [BURST_CNT_WIDTH-1:0] s_wr_burstcount,
    input  logic [DATA_WIDTH-1:0]      s_wr_writedata,
    input  logic [DATA_N_BYTES-1:0]    s_wr_byteenable,
    input  logic [USER_WIDTH-1:0]      s_wr_user,
    input  logic                       s_wr_error,
    output logic                       s_wr_waitrequest,
    output logic                       s_wr_writeresponsevalid,
    output logic                       s_wr_resp_error,

    output logic                       m_rd_read,
    output logic [ADDR_WIDTH-1:0]      m_rd_address,
    output logic [BURST_CNT_WIDTH-1:0] m_rd_burstcount,
    output logic [DATA_N_BYTES-1:0]    m_rd_byteenable,
    output logic [USER_WIDTH-1:0]      m_rd_user,
    input  logic                       m_rd_waitrequest,
    input  logic                       m_rd_readdatavalid,
    input  logic [DATA_WIDTH-1:0]      m_rd_readdata,

    output logic                       m_wr_write,
    output logic [ADDR_WIDTH-1:0]      m_wr_address,
    output logic [BURST_CNT_WIDTH-1:0] m_wr_burstcount,
    output logic [DATA_WIDTH-1:0]      m_wr_writedata,
    output logic [DATA_N_BYTES-1:0]    m_wr_byteenable,
    output logic [USER_WIDTH-1:0]      m_wr_user,
    input  logic                       m_wr_waitrequest,
    input  logic                       m_wr_writeresponsevalid,

    output logic [15:0]                err_rd_cnt,
    output logic [15:0]                err_wr_cnt
);

    localparam int PW = $clog2(MAX_OUTSTANDING);

    logic [PW:0]                rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [PW:0]                rd_errs_q, rd_errs_d;
    logic [BURST_CNT_WIDTH-1:0] rd_beat_q, rd_beat_d;
    logic                       rd_mem_err [MAX_OUTSTANDING];
    logic [BURST_CNT_WIDTH-1:0] rd_mem_bc  [MAX_OUTSTANDING];

    logic                       rd_empty, rd_full, rd_err_pending, rd_push, rd_pop;
    logic                       rd_head_err, rd_beat_fire, rd_last;
    logic [BURST_CNT_WIDTH-1:0] rd_head_bc;

    logic [PW:0]                wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    logic [PW:0]                wr_errs_q, wr_errs_d;
    logic [BURST_CNT_WIDTH-1:0] wr_rem_q, wr_rem_d;
    logic                       wr_cur_err_q, wr_cur_err_d;
    logic                       wr_mem_err [MAX_OUTSTANDING];

    logic                       wr_empty, wr_full, wr_err_pending, wr_sop, wr_sop_block;
    logic                       wr_cur_err, wr_accept, wr_push, wr_pop, wr_head_err;

    assign m_rd_address    = s_rd_address;
    assign m_rd_burstcount = s_rd_burstcount;
    assign m_rd_byteenable = s_rd_byteenable;
    assign m_rd_user       = s_rd_user;

    assign m_wr_address    = s_wr_address;
    assign m_wr_burstcount = s_wr_burstcount;
    assign m_wr_writedata  = s_wr_writedata;
    assign m_wr_byteenable = s_wr_byteenable;
    assign m_wr_user       = s_wr_user;

    // Reads stall while any fake completion is queued so host data never interleaves with it.
    always_comb begin
        rd_empty       = (rd_wptr_q == rd_rptr_q);
        rd_full        = ((rd_wptr_q - rd_rptr_q) == (PW+1)'(MAX_OUTSTANDING));
        rd_err_pending = (rd_errs_q != '0);
        rd_head_err    = rd_mem_err[rd_rptr_q[PW-1:0]];
        rd_head_bc     = rd_mem_bc[rd_rptr_q[PW-1:0]];

        s_rd_waitrequest = m_rd_waitrequest || rd_full || rd_err_pending;
        rd_push          = s_rd_read && !s_rd_waitrequest;
        m_rd_read        = s_rd_read && !s_rd_error && !rd_full && !rd_err_pending && !reset;

        rd_beat_fire       = !rd_empty && (rd_head_err || m_rd_readdatavalid);
        rd_last            = (rd_beat_q == rd_head_bc - 1'b1);
        rd_pop             = rd_beat_fire && rd_last;
        s_rd_readdatavalid = rd_beat_fire;
        s_rd_resp_error    = !rd_empty && rd_head_err;
        s_rd_readdata      = (!rd_empty && !rd_head_err) ? m_rd_readdata : '0;

        rd_beat_d = rd_beat_q;
        if (rd_beat_fire) begin
            rd_beat_d = rd_last ? '0 : rd_beat_q + 1'b1;
        end

        rd_wptr_d = rd_push ? rd_wptr_q + 1'b1 : rd_wptr_q;
        rd_rptr_d = rd_pop  ? rd_rptr_q + 1'b1 : rd_rptr_q;

        rd_errs_d = rd_errs_q;
        if (rd_push && s_rd_error && !(rd_pop && rd_head_err)) begin
            rd_errs_d = rd_errs_q + 1'b1;
        end else if (!(rd_push && s_rd_error) && rd_pop && rd_head_err) begin
            rd_errs_d = rd_errs_q - 1'b1;
        end
    end

    // Write stalls from this block only apply at SOP; a failed burst ignores host backpressure.
    always_comb begin
        wr_empty       = (wr_wptr_q == wr_rptr_q);
        wr_full        = ((wr_wptr_q - wr_rptr_q) == (PW+1)'(MAX_OUTSTANDING));
        wr_err_pending = (wr_errs_q != '0);
        wr_head_err    = wr_mem_err[wr_rptr_q[PW-1:0]];

        wr_sop       = (wr_rem_q == '0);
        wr_sop_block = wr_sop && (wr_full || wr_err_pending);
        wr_cur_err   = wr_sop ? s_wr_error : wr_cur_err_q;

        s_wr_waitrequest = wr_sop_block || (!wr_cur_err && m_wr_waitrequest);
        wr_accept        = s_wr_write && !s_wr_waitrequest;
        m_wr_write       = s_wr_write && !wr_cur_err && !wr_sop_block && !reset;
        wr_push          = wr_accept && wr_sop && !s_wr_user[UFLAG_NO_REPLY];

        wr_rem_d     = wr_rem_q;
        wr_cur_err_d = wr_cur_err_q;
        if (wr_accept) begin
            if (wr_sop) begin
                wr_rem_d     = s_wr_burstcount - 1'b1;
                wr_cur_err_d = s_wr_error;
            end else begin
                wr_rem_d = wr_rem_q - 1'b1;
            end
        end

        wr_pop                  = !wr_empty && (wr_head_err || m_wr_writeresponsevalid);
        s_wr_writeresponsevalid = wr_pop;
        s_wr_resp_error         = !wr_empty && wr_head_err;

        wr_wptr_d = wr_push ? wr_wptr_q + 1'b1 : wr_wptr_q;
        wr_rptr_d = wr_pop  ? wr_rptr_q + 1'b1 : wr_rptr_q;

        wr_errs_d = wr_errs_q;
        if (wr_push && s_wr_error && !(wr_pop && wr_head_err)) begin
            wr_errs_d = wr_errs_q + 1'b1;
        end else if (!(wr_push && s_wr_error) && wr_pop && wr_head_err) begin
            wr_errs_d = wr_errs_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_wptr_q    <= '0;
            rd_rptr_q    <= '0;
            rd_errs_q    <= '0;
            rd_beat_q    <= '0;
            wr_wptr_q    <= '0;
            wr_rptr_q    <= '0;
            wr_errs_q    <= '0;
            wr_rem_q     <= '0;
            wr_cur_err_q <= 1'b0;
        end else begin
            rd_wptr_q    <= rd_wptr_d;
            rd_rptr_q    <= rd_rptr_d;
            rd_errs_q    <= rd_errs_d;
            rd_beat_q    <= rd_beat_d;
            wr_wptr_q    <= wr_wptr_d;
            wr_rptr_q    <= wr_rptr_d;
            wr_errs_q    <= wr_errs_d;
            wr_rem_q     <= wr_rem_d;
            wr_cur_err_q <= wr_cur_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) begin
            rd_mem_err[rd_wptr_q[PW-1:0]] <= s_rd_error;
            rd_mem_bc[rd_wptr_q[PW-1:0]]  <= s_rd_burstcount;
        end
        if (wr_push) begin
            wr_mem_err[wr_wptr_q[PW-1:0]] <= s_wr_error;
        end
    end

`ifdef MPF_VTP_XLATE_ERR_STATS_EN
    logic [15:0] err_rd_cnt_q, err_rd_cnt_d, err_wr_cnt_q, err_wr_cnt_d;

    always_comb begin
        err_rd_cnt_d = err_rd_cnt_q;
        err_wr_cnt_d = err_wr_cnt_q;
        if (rd_push && s_rd_error && (err_rd_cnt_q != 16'hFFFF)) begin
            err_rd_cnt_d = err_rd_cnt_q + 16'd1;
        end
        if (wr_accept && wr_sop && s_wr_error && (err_wr_cnt_q != 16'hFFFF)) begin
            err_wr_cnt_d = err_wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_rd_cnt_q <= '0;
            err_wr_cnt_q <= '0;
        end else begin
            err_rd_cnt_q <= err_rd_cnt_d;
            err_wr_cnt_q <= err_wr_cnt_d;
        end
    end

    assign err_rd_cnt = err_rd_cnt_q;
    assign err_wr_cnt = err_wr_cnt_q;
`else
    assign err_rd_cnt = '0;
    assign err_wr_cnt = '0;
`endif

`ifndef SYNTHESIS
    // Host responses must always belong to a real head entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (m_rd_readdatavalid) begin
                assert (!rd_empty && !rd_head_err)
                    else $fatal(1, "unexpected host read response");
            end
            if (m_wr_writeresponsevalid) begin
                assert (!wr_empty && !wr_head_err)
                    else $fatal(1, "unexpected host write response");
            end
            if (rd_push) begin
                assert (s_rd_burstcount != '0) else $fatal(1, "read burstcount of zero");
            end
            if (wr_accept && wr_sop) begin
                assert (s_wr_burstcount != '0) else $fatal(1, "write burstcount of zero");
            end
        end
    end
`endif

endmodule

// File: doc/mpf_vtp_xlate_error_sink.md
Name: mpf_vtp_xlate_error_sink

Overview:
- Sits directly downstream of the VTP Avalon split-bus translator when that translator is built with FAIL_ON_ERROR=0. It consumes the translator's per-channel rd_error/wr_error flags and feeds the host (FIU) Avalon rdwr port.
- Requests that failed translation are never forwarded to the host. The block synthesizes in-order completions for them, flagged as errors, so the AFU never hangs waiting on a dropped request.
- Good requests pass through unchanged.

Parameters:
- ADDR_WIDTH, 48, address width.
- DATA_WIDTH, 512, data width; DATA_N_BYTES = DATA_WIDTH/8.
- BURST_CNT_WIDTH, 7, burstcount width.
- USER_WIDTH, 8, request user width.
- UFLAG_NO_REPLY, 0, wr_user bit index; write bursts with this bit set get no write response.
- MAX_OUTSTANDING, 64, depth of each tracking FIFO (power of 2).

Ports:
- clk in 1: clock.
- reset in 1: async, active-high.
- s_rd_read, s_rd_address, s_rd_burstcount, s_rd_byteenable, s_rd_user in 1/ADDR/BC/DNB/USER: read request from the translator.
- s_rd_error in 1: translation failed for the current read.
- s_rd_waitrequest out 1: read backpressure to the translator.
- s_rd_readdatavalid, s_rd_readdata, s_rd_resp_error out 1/DATA/1: read response; s_rd_resp_error marks a synthesized beat.
- s_wr_write, s_wr_address, s_wr_burstcount, s_wr_writedata, s_wr_byteenable, s_wr_user, s_wr_error in: write request; s_wr_error is held for the whole failed burst.
- s_wr_waitrequest out 1: write backpressure to the translator.
- s_wr_writeresponsevalid, s_wr_resp_error out 1/1: write response; s_wr_resp_error marks a synthesized response.
- m_rd_* / m_wr_* (read, address, burstcount, byteenable, user, writedata, write) out: requests to the host.
- m_rd_waitrequest, m_wr_waitrequest in 1: host backpressure.
- m_rd_readdatavalid, m_rd_readdata, m_wr_writeresponsevalid in: host responses; these cannot be backpressured.
- err_rd_cnt, err_wr_cnt out 16: error statistics (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert): all FIFOs empty, counters 0, all valids/outputs 0.
- Read tracking FIFO entry = {is_err, burstcount}. One entry is pushed per accepted read, i.e. s_rd_read && !s_rd_waitrequest.
- s_rd_waitrequest = m_rd_waitrequest || rd_fifo_full || rd_err_pending.
  - rd_err_pending = number of error entries in the FIFO is nonzero.
  - Consequence: no host read is issued while a synthesized completion is pending, so host data can never collide with fake beats.
- m_rd_read = s_rd_read && !s_rd_error && !rd_fifo_full && !rd_err_pending. Request fields pass through combinationally (0-cycle).
- Response engine, driven by the FIFO head; beat counter = head.burstcount.
  - Head is real: forward each m_rd_readdatavalid beat combinationally with s_rd_resp_error=0; decrement the counter; pop at the last beat.
  - Head is error: emit one registered beat per cycle, readdata=0, s_rd_resp_error=1; pop after burstcount beats.
  - The first fake beat comes 1 cycle after the entry reaches the head (cycle N+1 if accepted into an empty FIFO at cycle N).
  - A host readdatavalid arriving while the FIFO is empty, or while the head is an error entry, is a protocol violation: sim $fatal.
- Write SOP tracking uses a burst counter. The SOP beat pushes {is_err} into the write FIFO unless s_wr_user[UFLAG_NO_REPLY] is set.
- Full-FIFO and error-pending stalls apply only at SOP. A burst in progress is never stalled by the block itself.
- s_wr_waitrequest = (sop && (wr_fifo_full || wr_err_pending)) || (!cur_err && m_wr_waitrequest).
  - cur_err = s_wr_error at SOP, latched for the remaining beats.
  - Failed bursts: every beat is accepted and dropped; m_wr_write stays 0.
- Write response engine:
  - Head real: forward m_wr_writeresponsevalid and pop.
  - Head error: emit one registered response with s_wr_resp_error=1 the cycle after it becomes head, then pop.
- Simultaneous push and pop on the same FIFO in one cycle is legal. Full is evaluated before the push.
- burstcount = 0 is illegal: sim assertion.

Optional Feature:
- Macro: MPF_VTP_XLATE_ERR_STATS_EN.
- Defined: err_rd_cnt / err_wr_cnt count accepted failed read requests / failed write bursts (counted at SOP). Both are 16-bit, saturate at 0xFFFF, and are cleared by reset.
- Undefined: both ports are tied to 0 and no counters are built.

Test Plan:
- Good reads: 3 reads, burstcount 2, no error → 3 host reads; 6 beats forwarded in order, resp_error=0.
- Error read: read bc=4 with s_rd_error=1 into an empty block at cycle N → no m_rd_read; 4 beats at N+1..N+4 with readdata=0, resp_error=1.
- Ordering: good read bc=2, then error read bc=1; host data delayed 10 cycles → the 2 real beats come first, then 1 fake beat. s_rd_waitrequest stays high from error acceptance until the fake beat pops.
- Failed write: bc=3 write with s_wr_error=1 → 3 beats accepted, m_wr_write never set, one response with resp_error=1. A NO_REPLY failed burst produces no response.
- Full FIFO: MAX_OUTSTANDING=4, 4 good reads unanswered → 5th read sees waitrequest=1; one host response beat completing a bc=1 read releases it.
- Reset mid-burst during fake read beats → outputs 0 immediately; post-reset traffic behaves as in the good-read case. With MPF_VTP_XLATE_ERR_STATS_EN, err_rd_cnt=0 after reset and increments by 1 per failed read.
